snake_body_tracker: RTL and testbench

- Owns the snake's segment coordinates on the 160x120 game grid and advances them at a fixed move rate in the current direction.
- Sits directly downstream of the random target generator: it consumes RAND_ADDRH/RAND_ADDRV, and it produces the REACHED pulse that the generator uses to latch a new target.
- Also answers per-pixel "is snake here" queries from the VGA colour path, keeps score, and flags self-collision to the master state machine.

---
 rtl/snake_body_tracker.sv | 151 +++++++++++++++
 tb/tb_snake_body_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// Snake segment store for the 160x120 grid: steps the body once per move tick,
// detects target hits and self-collision, and answers per-pixel body/head queries.
module snake_body_tracker #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 5000000,
  parameter int H_MAX    = 160,
  parameter int V_MAX    = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MASTER_STATE,
  input  logic [1:0] DIR_IN,
  input  logic [7:0] RAND_ADDRH,
  input  logic [6:0] RAND_ADDRV,
  input  logic [7:0] ADDRH,
  input  logic [6:0] ADDRV,
  output logic       REACHED,
  output logic       COLLISION,
  output logic       SNAKE_PIXEL,
  output logic       HEAD_PIXEL,
  output logic [4:0] LENGTH,
  output logic [7:0] SCORE
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  state_t          state_q, state_d;
  logic [7:0]      seg_x_q [MAX_LEN];
  logic [6:0]      seg_y_q [MAX_LEN];
  logic [4:0]      length_q;
  logic [7:0]      score_q;
  logic [TW-1:0]   tick_q;
  logic [1:0]      dir_q;
  logic [1:0]      pending_dir_q;
  logic            reached_q;
  logic            collision_q;

  logic            init;
  logic            run_en;
  logic            move;
  logic [1:0]      new_dir;
  logic [7:0]      next_x;
  logic [6:0]      next_y;
  logic            hit_target;
  logic            hit_self;
  logic [MAX_LEN-1:0] body_hit;
  logic [MAX_LEN-1:0] pix_hit;

  assign init   = RESET || (MASTER_STATE == 2'b00);
  assign run_en = (state_q == RUN) && (MASTER_STATE == 2'b01);
  assign move   = run_en && (tick_q == TW'(TICK_DIV - 1));

  // A request for the exact opposite direction is ignored; opposites differ only in bit 1.
  assign new_dir = ((pending_dir_q ^ dir_q) == 2'b10) ? dir_q : pending_dir_q;

  always_comb begin
    next_x = seg_x_q[0];
    next_y = seg_y_q[0];
    case (new_dir)
      DIR_UP:    next_y = (seg_y_q[0] == 7'd0) ? 7'(V_MAX - 1) : seg_y_q[0] - 7'd1;
      DIR_RIGHT: next_x = (seg_x_q[0] == 8'(H_MAX - 1)) ? 8'd0 : seg_x_q[0] + 8'd1;
      DIR_DOWN:  next_y = (seg_y_q[0] == 7'(V_MAX - 1)) ? 7'd0 : seg_y_q[0] + 7'd1;
      DIR_LEFT:  next_x = (seg_x_q[0] == 8'd0) ? 8'(H_MAX - 1) : seg_x_q[0] - 8'd1;
      default:   next_x = seg_x_q[0];
    endcase
  end

  // The tail index (LENGTH-1) is excluded from the body test because it vacates on this move.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg_cmp
      assign body_hit[gi] = ((5'(gi) + 5'd1) < length_q) &&
                            (seg_x_q[gi] == next_x) && (seg_y_q[gi] == next_y);
      assign pix_hit[gi]  = (5'(gi) < length_q) &&
                            (seg_x_q[gi] == ADDRH) && (seg_y_q[gi] == ADDRV);
    end
  endgenerate

  assign hit_self   = |body_hit;
  assign hit_target = (next_x == RAND_ADDRH) && (next_y == RAND_ADDRV);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (MASTER_STATE == 2'b01) state_d = RUN;
      RUN: begin
        if (MASTER_STATE[1])      state_d = IDLE;
        else if (move && hit_self) state_d = DEAD;
      end
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
    if (init) state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    pending_dir_q <= DIR_IN;
    if (init) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= 8'(80 - k);
        seg_y_q[k] <= 7'd60;
      end
      length_q    <= 5'(INIT_LEN);
      score_q     <= 8'd0;
      tick_q      <= '0;
      dir_q       <= DIR_RIGHT;
      reached_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      reached_q <= 1'b0;
      if (run_en) tick_q <= move ? '0 : tick_q + TW'(1);
      if (move) begin
        dir_q <= new_dir;
        if (hit_self) begin
          collision_q <= 1'b1;
        end else begin
          for (int k = 1; k < MAX_LEN; k++) begin
            seg_x_q[k] <= seg_x_q[k-1];
            seg_y_q[k] <= seg_y_q[k-1];
          end
          seg_x_q[0] <= next_x;
          seg_y_q[0] <= next_y;
          if (hit_target) begin
            reached_q <= 1'b1;
            if (length_q < 5'(MAX_LEN)) length_q <= length_q + 5'd1;
            if (score_q != 8'hFF)      score_q  <= score_q + 8'd1;
          end
        end
      end
    end
  end

  assign REACHED     = reached_q;
  assign COLLISION   = collision_q;
  assign SNAKE_PIXEL = |pix_hit;
  assign HEAD_PIXEL  = (seg_x_q[0] == ADDRH) && (seg_y_q[0] == ADDRV);
  assign LENGTH      = length_q;
  assign SCORE       = score_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: stimulus queues expected query/status
// snapshots, a negedge monitor pops and compares them against the DUT outputs.
module tb_snake_body_tracker;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] MASTER_STATE;
  logic [1:0] DIR_IN;
  logic [7:0] RAND_ADDRH;
  logic [6:0] RAND_ADDRV;
  logic [7:0] ADDRH;
  logic [6:0] ADDRV;
  logic       REACHED;
  logic       COLLISION;
  logic       SNAKE_PIXEL;
  logic       HEAD_PIXEL;
  logic [4:0] LENGTH;
  logic [7:0] SCORE;

  always #5 CLK = ~CLK;

  snake_body_tracker #(
    .MAX_LEN(16), .INIT_LEN(4), .TICK_DIV(4), .H_MAX(160), .V_MAX(120)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE), .DIR_IN(DIR_IN),
    .RAND_ADDRH(RAND_ADDRH), .RAND_ADDRV(RAND_ADDRV), .ADDRH(ADDRH), .ADDRV(ADDRV),
    .REACHED(REACHED), .COLLISION(COLLISION), .SNAKE_PIXEL(SNAKE_PIXEL),
    .HEAD_PIXEL(HEAD_PIXEL), .LENGTH(LENGTH), .SCORE(SCORE)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       es;
    logic       eh;
    logic [4:0] el;
    logic [7:0] esc;
    logic       ec;
    logic       er;
  } probe_t;

  probe_t probe_q[$];
  string  name_q[$];
  int     total = 0;
  int     bad = 0;
  int     reach_seen = 0;
  bit     do_final = 0;
  bit     final_done = 0;
  probe_t mon_p;
  string  mon_n;

  // Monitor: one popped expectation per falling edge, plus REACHED pulse counting.
  always @(negedge CLK) begin
    if (REACHED === 1'b1) reach_seen++;
    if (probe_q.size() > 0) begin
      mon_p = probe_q.pop_front();
      mon_n = name_q.pop_front();
      total++;
      if ({SNAKE_PIXEL, HEAD_PIXEL, LENGTH, SCORE, COLLISION, REACHED} !==
          {mon_p.es, mon_p.eh, mon_p.el, mon_p.esc, mon_p.ec, mon_p.er}) begin
        bad++;
        $display("FAIL %s q=(%0d,%0d): got snake=%b head=%b len=%0d score=%0d coll=%b reached=%b, want snake=%b head=%b len=%0d score=%0d coll=%b reached=%b",
                 mon_n, mon_p.x, mon_p.y, SNAKE_PIXEL, HEAD_PIXEL, LENGTH, SCORE, COLLISION, REACHED,
                 mon_p.es, mon_p.eh, mon_p.el, mon_p.esc, mon_p.ec, mon_p.er);
      end else begin
        $display("ok   %s q=(%0d,%0d) snake=%b head=%b len=%0d score=%0d coll=%b reached=%b",
                 mon_n, mon_p.x, mon_p.y, SNAKE_PIXEL, HEAD_PIXEL, LENGTH, SCORE, COLLISION, REACHED);
      end
    end
    if (do_final && !final_done) begin
      total++;
      if (reach_seen != 1) begin
        bad++;
        $display("FAIL reach_pulses: got %0d cycles of REACHED, want 1", reach_seen);
      end else begin
        $display("ok   reach_pulses %0d", reach_seen);
      end
      final_done = 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe(input string nm, input int x, input int y, input bit es, input bit eh,
                       input int el, input int esc, input bit ec, input bit er);
    probe_t p;
    p.x = 8'(x); p.y = 7'(y); p.es = es; p.eh = eh;
    p.el = 5'(el); p.esc = 8'(esc); p.ec = ec; p.er = er;
    ADDRH = p.x;
    ADDRV = p.y;
    probe_q.push_back(p);
    name_q.push_back(nm);
    tick();
  endtask

  // Run until the head reaches (x,y) (bounded), then freeze the game so positions hold.
  task automatic step(input logic [1:0] d, input int x, input int y);
    DIR_IN = d;
    ADDRH = 8'(x);
    ADDRV = 7'(y);
    MASTER_STATE = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (HEAD_PIXEL) break;
    end
    MASTER_STATE = 2'b10;
    tick();
  endtask

  initial begin
    RESET = 1'b1; MASTER_STATE = 2'b00; DIR_IN = 2'b01;
    RAND_ADDRH = 8'd200; RAND_ADDRV = 7'd100; ADDRH = 8'd0; ADDRV = 7'd0;
    repeat (3) tick();
    RESET = 1'b0;

    probe("rst_head",   80, 60, 1, 1, 4, 0, 0, 0);
    probe("rst_tail",   77, 60, 1, 0, 4, 0, 0, 0);
    probe("rst_beyond", 76, 60, 0, 0, 4, 0, 0, 0);

    // First move lands on the target: 4 RUN clocks after the IDLE->RUN edge.
    RAND_ADDRH = 8'd81; RAND_ADDRV = 7'd60; MASTER_STATE = 2'b01; DIR_IN = 2'b01;
    for (int i = 0; i < 5; i++) probe("pre_move", 81, 60, 0, 0, 4, 0, 0, 0);
    probe("first_move", 81, 60, 1, 1, 5, 1, 0, 1);
    MASTER_STATE = 2'b10; RAND_ADDRH = 8'd200; RAND_ADDRV = 7'd100;
    probe("reach_drop",  81, 60, 1, 1, 5, 1, 0, 0);
    probe("grow_tail",   77, 60, 1, 0, 5, 1, 0, 0);
    probe("grow_beyond", 76, 60, 0, 0, 5, 1, 0, 0);

    step(2'b11, 82, 60);
    probe("no_reverse",     82, 60, 1, 1, 5, 1, 0, 0);
    probe("no_reverse_old", 81, 60, 1, 0, 5, 1, 0, 0);
    step(2'b00, 82, 59);
    probe("turn_up", 82, 59, 1, 1, 5, 1, 0, 0);
    step(2'b11, 81, 59);
    probe("turn_left", 81, 59, 1, 1, 5, 1, 0, 0);

    // Turning down lands on body segment 3 while the target sits there too.
    RAND_ADDRH = 8'd81; RAND_ADDRV = 7'd60; DIR_IN = 2'b10; MASTER_STATE = 2'b01;
    ADDRH = 8'd81; ADDRV = 7'd59;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (COLLISION) break;
    end
    probe("collide", 81, 59, 1, 1, 5, 1, 1, 0);
    repeat (8) tick();
    probe("dead_frozen", 81, 59, 1, 1, 5, 1, 1, 0);
    probe("dead_body",   80, 60, 1, 0, 5, 1, 1, 0);

    MASTER_STATE = 2'b00; RAND_ADDRH = 8'd200; RAND_ADDRV = 7'd100;
    tick();
    MASTER_STATE = 2'b10;
    probe("reinit_head", 80, 60, 1, 1, 4, 0, 0, 0);
    probe("reinit_old",  81, 59, 0, 0, 4, 0, 0, 0);

    MASTER_STATE = 2'b01; DIR_IN = 2'b01;
    for (int i = 0; i < 5; i++) probe("reinit_wait", 81, 60, 0, 0, 4, 0, 0, 0);
    probe("reinit_move", 81, 60, 1, 1, 4, 0, 0, 0);
    MASTER_STATE = 2'b10;
    tick();

    // Down, left, up lands on the vacating tail: must not count as a collision.
    step(2'b10, 81, 61);
    step(2'b11, 80, 61);
    step(2'b00, 80, 60);
    probe("tail_excluded", 80, 60, 1, 1, 4, 0, 0, 0);

    for (int i = 1; i <= 60; i++) step(2'b00, 80, 60 - i);
    probe("top_edge", 80, 0, 1, 1, 4, 0, 0, 0);
    step(2'b00, 80, 119);
    probe("wrap_up",   80, 119, 1, 1, 4, 0, 0, 0);
    probe("wrap_body", 80, 0,   1, 0, 4, 0, 0, 0);

    for (int x = 81; x <= 159; x++) step(2'b01, x, 119);
    probe("right_edge", 159, 119, 1, 1, 4, 0, 0, 0);
    step(2'b01, 0, 119);
    probe("wrap_right",  0,   119, 1, 1, 4, 0, 0, 0);
    probe("wrap_r_body", 159, 119, 1, 0, 4, 0, 0, 0);
    step(2'b10, 0, 0);
    probe("wrap_down", 0, 0, 1, 1, 4, 0, 0, 0);
    step(2'b11, 159, 0);
    probe("wrap_left", 159, 0, 1, 1, 4, 0, 0, 0);

    do_final = 1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
